ex_mem_latch: RTL and testbench

- EX/MEM pipeline stage register directly downstream of the execute-stage ALU in the 16-bit five-stage pipeline.
- Captures the ALU result and flags (Out, Ofl, Z, ltz), evaluates set-condition and branch outcomes from those flags, and holds the result with memory/writeback control for the MEM stage.
- Supports stall (hold), flush (bubble insertion) and a one-cycle overflow-trap pulse.

---
 rtl/ex_mem_latch_pkg.sv | 30 +++
 rtl/ex_mem_latch_cond_eval.sv | 50 +++++
 rtl/ex_mem_latch.sv | 152 +++++++++++++++
 tb/tb_ex_mem_latch.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_latch_pkg.sv
// ex_mem_latch_pkg
// Shared definitions for the EX/MEM pipeline stage:
//   - default datapath and register-address widths
//   - set-condition select encodings (cond_sel)
//   - branch/jump type encodings (br_type)
package ex_mem_latch_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_REG_AW = 3;

  // Selects what the stage writes into mem_result.
  typedef enum logic [2:0] {
    COND_NONE = 3'b000,  // plain ALU result
    COND_SEQ  = 3'b001,  // result == 0
    COND_SLT  = 3'b010,  // result < 0
    COND_SLE  = 3'b011,  // result <= 0
    COND_SCO  = 3'b100   // adder carry-out
  } cond_sel_e;

  // Selects the branch decision registered into br_taken.
  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_EQZ  = 3'b001,
    BR_NEZ  = 3'b010,
    BR_LTZ  = 3'b011,
    BR_GEZ  = 3'b100,
    BR_JMP  = 3'b101
  } br_type_e;

endpackage

// File: rtl/ex_mem_latch_cond_eval.sv
// ex_mem_latch_cond_eval
// Combinational evaluation of set-condition results and branch outcomes
// from the ALU flags.
// Ports:
//   alu_out          in  ALU result, passed through for non-set selects
//   alu_z/ltz/cout   in  ALU flags (ltz already overflow-corrected)
//   cond_sel         in  set-condition select
//   br_type          in  branch/jump type
//   result_sel_value out value destined for mem_result
//   taken            out raw branch decision (not yet qualified by valid)
module ex_mem_latch_cond_eval
  import ex_mem_latch_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_z,
  input  logic              alu_ltz,
  input  logic              alu_cout,
  input  logic [2:0]        cond_sel,
  input  logic [2:0]        br_type,
  output logic [DATA_W-1:0] result_sel_value,
  output logic              taken
);

  always_comb begin
    result_sel_value = alu_out;
    case (cond_sel)
      COND_SEQ: result_sel_value = {{(DATA_W-1){1'b0}}, alu_z};
      // A zero result is never "less than", even if ltz were set.
      COND_SLT: result_sel_value = {{(DATA_W-1){1'b0}}, alu_ltz & ~alu_z};
      COND_SLE: result_sel_value = {{(DATA_W-1){1'b0}}, alu_ltz | alu_z};
      COND_SCO: result_sel_value = {{(DATA_W-1){1'b0}}, alu_cout};
      default:  result_sel_value = alu_out;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (br_type)
      BR_EQZ:  taken = alu_z;
      BR_NEZ:  taken = ~alu_z;
      BR_LTZ:  taken = alu_ltz;
      BR_GEZ:  taken = ~alu_ltz;
      BR_JMP:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_mem_latch.sv
// ex_mem_latch
// EX/MEM pipeline register. Captures the ALU result (or a set-condition
// value derived from the flags), the branch decision and target, store data
// and MEM/WB control. Supports stall (hold), flush (bubble) and a one-cycle
// overflow-trap pulse.
// Priority per rising edge: reset > flush > stall > load.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   stall, flush            pipeline control
//   ex_valid, alu_*         EX-stage instruction and ALU outputs
//   cond_sel, br_type       condition / branch selects
//   br_target, st_data      branch target, store data
//   ofl_en                  instruction traps on signed overflow
//   mem_rd_in, mem_wr_in, wr_en_in, wr_reg_in   control to carry forward
//   mem_valid .. ofl_trap   registered MEM-stage outputs
module ex_mem_latch
  import ex_mem_latch_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_ofl,
  input  logic              alu_z,
  input  logic              alu_ltz,
  input  logic              alu_cout,
  input  logic [2:0]        cond_sel,
  input  logic [2:0]        br_type,
  input  logic [DATA_W-1:0] br_target,
  input  logic              ofl_en,
  input  logic [DATA_W-1:0] st_data,
  input  logic              mem_rd_in,
  input  logic              mem_wr_in,
  input  logic              wr_en_in,
  input  logic [REG_AW-1:0] wr_reg_in,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_result,
  output logic [DATA_W-1:0] mem_st_data,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              wr_en,
  output logic [REG_AW-1:0] wr_reg,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_pc,
  output logic              ofl_trap
);

  logic [DATA_W-1:0] result_sel_value;
  logic              taken;

  ex_mem_latch_cond_eval #(.DATA_W(DATA_W)) u_cond_eval (
    .alu_out          (alu_out),
    .alu_z            (alu_z),
    .alu_ltz          (alu_ltz),
    .alu_cout         (alu_cout),
    .cond_sel         (cond_sel),
    .br_type          (br_type),
    .result_sel_value (result_sel_value),
    .taken            (taken)
  );

  logic              valid_q,    valid_d;
  logic [DATA_W-1:0] result_q,   result_d;
  logic [DATA_W-1:0] st_data_q,  st_data_d;
  logic              rd_q,       rd_d;
  logic              wr_q,       wr_d;
  logic              wr_en_q,    wr_en_d;
  logic [REG_AW-1:0] wr_reg_q,   wr_reg_d;
  logic              br_taken_q, br_taken_d;
  logic [DATA_W-1:0] br_pc_q,    br_pc_d;
  logic              trap_q,     trap_d;

  logic trap_now;
  assign trap_now = ex_valid & ofl_en & alu_ofl;

  always_comb begin
    // Default: hold. The trap is a pulse, so it never holds.
    valid_d    = valid_q;
    result_d   = result_q;
    st_data_d  = st_data_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    wr_en_d    = wr_en_q;
    wr_reg_d   = wr_reg_q;
    br_taken_d = br_taken_q;
    br_pc_d    = br_pc_q;
    trap_d     = 1'b0;
    if (flush) begin
      // Bubble: only control is cleared; data registers simply hold.
      valid_d    = 1'b0;
      rd_d       = 1'b0;
      wr_d       = 1'b0;
      wr_en_d    = 1'b0;
      br_taken_d = 1'b0;
    end else if (!stall) begin
      valid_d    = ex_valid;
      result_d   = result_sel_value;
      st_data_d  = st_data;
      rd_d       = ex_valid & mem_rd_in;
      wr_d       = ex_valid & mem_wr_in;
      // A trapping instruction must not write back its corrupt result.
      wr_en_d    = ex_valid & wr_en_in & ~trap_now;
      wr_reg_d   = wr_reg_in;
      br_taken_d = ex_valid & taken;
      br_pc_d    = br_target;
      trap_d     = trap_now;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      result_q   <= '0;
      st_data_q  <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_reg_q   <= '0;
      br_taken_q <= 1'b0;
      br_pc_q    <= '0;
      trap_q     <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      result_q   <= result_d;
      st_data_q  <= st_data_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      wr_en_q    <= wr_en_d;
      wr_reg_q   <= wr_reg_d;
      br_taken_q <= br_taken_d;
      br_pc_q    <= br_pc_d;
      trap_q     <= trap_d;
    end
  end

  assign mem_valid   = valid_q;
  assign mem_result  = result_q;
  assign mem_st_data = st_data_q;
  assign mem_rd      = rd_q;
  assign mem_wr      = wr_q;
  assign wr_en       = wr_en_q;
  assign wr_reg      = wr_reg_q;
  assign br_taken    = br_taken_q;
  assign br_pc       = br_pc_q;
  assign ofl_trap    = trap_q;

endmodule

// File: tb/tb_ex_mem_latch.sv
// tb_ex_mem_latch
// Self-checking bench for ex_mem_latch: a behavioural model updated on every
// rising edge and compared against the DUT 1 time unit later, plus directed
// scenarios with literal expected values and a randomized phase.
module tb_ex_mem_latch;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        stall, flush, ex_valid;
  logic [15:0] alu_out;
  logic        alu_ofl, alu_z, alu_ltz, alu_cout;
  logic [2:0]  cond_sel, br_type;
  logic [15:0] br_target, st_data;
  logic        ofl_en, mem_rd_in, mem_wr_in, wr_en_in;
  logic [2:0]  wr_reg_in;

  logic        mem_valid, mem_rd, mem_wr, wr_en, br_taken, ofl_trap;
  logic [15:0] mem_result, mem_st_data, br_pc;
  logic [2:0]  wr_reg;

  ex_mem_latch dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .alu_out(alu_out), .alu_ofl(alu_ofl),
    .alu_z(alu_z), .alu_ltz(alu_ltz), .alu_cout(alu_cout),
    .cond_sel(cond_sel), .br_type(br_type), .br_target(br_target),
    .ofl_en(ofl_en), .st_data(st_data), .mem_rd_in(mem_rd_in),
    .mem_wr_in(mem_wr_in), .wr_en_in(wr_en_in), .wr_reg_in(wr_reg_in),
    .mem_valid(mem_valid), .mem_result(mem_result),
    .mem_st_data(mem_st_data), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .wr_en(wr_en), .wr_reg(wr_reg), .br_taken(br_taken), .br_pc(br_pc),
    .ofl_trap(ofl_trap)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic        e_valid, e_rd, e_wr, e_wren, e_br, e_trap;
  logic [15:0] e_result, e_st, e_pc;
  logic [2:0]  e_wreg;
  bit          data_known = 1'b0;  // data registers are unspecified after a flush
  bit          model_live = 1'b0;

  function automatic logic [15:0] model_result(input logic [2:0] sel,
      input logic [15:0] a, input logic z, input logic ltz, input logic co);
    case (sel)
      3'd1:    return z ? 16'd1 : 16'd0;
      3'd2:    return (ltz && !z) ? 16'd1 : 16'd0;
      3'd3:    return (ltz || z) ? 16'd1 : 16'd0;
      3'd4:    return co ? 16'd1 : 16'd0;
      default: return a;
    endcase
  endfunction

  function automatic logic model_taken(input logic [2:0] t, input logic z,
                                       input logic ltz);
    case (t)
      3'd1:    return z;
      3'd2:    return !z;
      3'd3:    return ltz;
      3'd4:    return !ltz;
      3'd5:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Single compare process: update the model at each edge from the inputs
  // the DUT saw, then compare once the DUT has settled.
  always @(posedge clk) begin
    if (!rst_n) begin
      {e_valid, e_rd, e_wr, e_wren, e_br, e_trap} = '0;
      e_result = '0; e_st = '0; e_pc = '0; e_wreg = '0;
      data_known = 1'b1;
      model_live = 1'b1;
    end else if (flush) begin
      {e_valid, e_rd, e_wr, e_wren, e_br, e_trap} = '0;
      data_known = 1'b0;
    end else if (stall) begin
      e_trap = 1'b0;
    end else begin
      e_valid  = ex_valid;
      e_trap   = ex_valid && ofl_en && alu_ofl;
      e_rd     = ex_valid && mem_rd_in;
      e_wr     = ex_valid && mem_wr_in;
      e_wren   = ex_valid && wr_en_in && !e_trap;
      e_br     = ex_valid && model_taken(br_type, alu_z, alu_ltz);
      e_result = model_result(cond_sel, alu_out, alu_z, alu_ltz, alu_cout);
      e_st     = st_data;
      e_pc     = br_target;
      e_wreg   = wr_reg_in;
      data_known = 1'b1;
    end
    #1;
    if (model_live) begin
      check("mem_valid", {31'd0, mem_valid}, {31'd0, e_valid});
      check("mem_rd",    {31'd0, mem_rd},    {31'd0, e_rd});
      check("mem_wr",    {31'd0, mem_wr},    {31'd0, e_wr});
      check("wr_en",     {31'd0, wr_en},     {31'd0, e_wren});
      check("br_taken",  {31'd0, br_taken},  {31'd0, e_br});
      check("ofl_trap",  {31'd0, ofl_trap},  {31'd0, e_trap});
      if (data_known) begin
        check("mem_result",  {16'd0, mem_result},  {16'd0, e_result});
        check("mem_st_data", {16'd0, mem_st_data}, {16'd0, e_st});
        check("br_pc",       {16'd0, br_pc},       {16'd0, e_pc});
        check("wr_reg",      {29'd0, wr_reg},      {29'd0, e_wreg});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0; ex_valid = 1'b0;
    alu_out = '0; alu_ofl = 1'b0; alu_z = 1'b0; alu_ltz = 1'b0;
    alu_cout = 1'b0; cond_sel = '0; br_type = '0; br_target = '0;
    ofl_en = 1'b0; st_data = '0; mem_rd_in = 1'b0; mem_wr_in = 1'b0;
    wr_en_in = 1'b0; wr_reg_in = '0;
  endtask

  task automatic randomize_inputs();
    ex_valid  = 1'($urandom_range(0, 3) != 0);
    alu_out   = 16'($urandom_range(0, 16'hFFFF));
    alu_ofl   = 1'($urandom_range(0, 3) == 0);
    alu_z     = 1'($urandom_range(0, 1));
    alu_ltz   = 1'($urandom_range(0, 1));
    alu_cout  = 1'($urandom_range(0, 1));
    cond_sel  = 3'($urandom_range(0, 7));
    br_type   = 3'($urandom_range(0, 7));
    br_target = 16'($urandom_range(0, 16'hFFFF));
    ofl_en    = 1'($urandom_range(0, 1));
    st_data   = 16'($urandom_range(0, 16'hFFFF));
    mem_rd_in = 1'($urandom_range(0, 1));
    mem_wr_in = 1'($urandom_range(0, 1));
    wr_en_in  = 1'($urandom_range(0, 1));
    wr_reg_in = 3'($urandom_range(0, 7));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},  {31'd0, mem_valid}, 32'd0);
    check({tag, "_result"}, {16'd0, mem_result}, 32'd0);
    check({tag, "_st"},     {16'd0, mem_st_data}, 32'd0);
    check({tag, "_ctrl"},   {26'd0, mem_rd, mem_wr, wr_en, br_taken, ofl_trap, 1'b0}, 32'd0);
    check({tag, "_wreg"},   {29'd0, wr_reg}, 32'd0);
    check({tag, "_pc"},     {16'd0, br_pc}, 32'd0);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    // Reset for two edges with every other input high.
    rst_n = 1'b0; stall = 1'b1; flush = 1'b1; ex_valid = 1'b1;
    alu_out = '1; alu_ofl = 1'b1; alu_z = 1'b1; alu_ltz = 1'b1;
    alu_cout = 1'b1; cond_sel = '1; br_type = '1; br_target = '1;
    ofl_en = 1'b1; st_data = '1; mem_rd_in = 1'b1; mem_wr_in = 1'b1;
    wr_en_in = 1'b1; wr_reg_in = '1;
    @(negedge clk); @(negedge clk);
    check_all_zero("reset");

    // SLT right after release.
    idle();
    alu_out = 16'hFFFE; alu_ltz = 1'b1; cond_sel = 3'b010;
    ex_valid = 1'b1; wr_en_in = 1'b1;
    @(negedge clk);
    check("slt_result", {16'd0, mem_result}, 32'h0001);
    check("slt_wr_en",  {31'd0, wr_en}, 32'd1);
    check("slt_valid",  {31'd0, mem_valid}, 32'd1);

    // BEQZ taken, then not taken.
    idle();
    ex_valid = 1'b1; br_type = 3'b001; alu_z = 1'b1; br_target = 16'h0040;
    @(negedge clk);
    check("beqz_taken", {31'd0, br_taken}, 32'd1);
    check("beqz_pc",    {16'd0, br_pc}, 32'h0040);
    alu_z = 1'b0;
    @(negedge clk);
    check("beqz_not_taken", {31'd0, br_taken}, 32'd0);
    check("beqz_pc2",       {16'd0, br_pc}, 32'h0040);

    // Load 0x1234 then stall three cycles with changing inputs.
    idle();
    ex_valid = 1'b1; alu_out = 16'h1234; wr_en_in = 1'b1;
    @(negedge clk);
    check("load_1234", {16'd0, mem_result}, 32'h1234);
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      stall = 1'b1;
      @(negedge clk);
      check("stall_hold", {16'd0, mem_result}, 32'h1234);
      check("stall_valid", {31'd0, mem_valid}, 32'd1);
    end
    flush = 1'b1;
    @(negedge clk);
    check("stall_flush_valid", {31'd0, mem_valid}, 32'd0);
    check("stall_flush_wr_en", {31'd0, wr_en}, 32'd0);

    // Overflow trap pulses once, suppresses write-back, survives stalls.
    idle();
    ex_valid = 1'b1; ofl_en = 1'b1; alu_ofl = 1'b1; wr_en_in = 1'b1;
    @(negedge clk);
    check("trap_set",   {31'd0, ofl_trap}, 32'd1);
    check("trap_wr_en", {31'd0, wr_en}, 32'd0);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("trap_stall_clear", {31'd0, ofl_trap}, 32'd0);
      check("trap_stall_wr_en", {31'd0, wr_en}, 32'd0);
    end
    stall = 1'b0; ofl_en = 1'b0;
    @(negedge clk);
    check("no_trap",       {31'd0, ofl_trap}, 32'd0);
    check("no_trap_wr_en", {31'd0, wr_en}, 32'd1);

    // Reset while stalled on valid data.
    idle();
    ex_valid = 1'b1; alu_out = 16'hBEEF; st_data = 16'h5A5A;
    br_target = 16'h0100; wr_reg_in = 3'd5; mem_rd_in = 1'b1;
    @(negedge clk);
    check("pre_reset_result", {16'd0, mem_result}, 32'hBEEF);
    stall = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("reset_stall");

    // Randomized phase.
    idle();
    for (int i = 0; i < 600; i++) begin
      randomize_inputs();
      rst_n = 1'($urandom_range(0, 59) != 0);
      stall = 1'($urandom_range(0, 4) == 0);
      flush = 1'($urandom_range(0, 7) == 0);
      @(negedge clk);
    end

    idle();
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
